dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-side bridge between the nano_rv32i core's combinational data port and a pipelined req/gnt/rvalid memory bus. It registers each core access, issues exactly one bus transaction for it, stalls the core until that transaction completes, and then returns load data. Loads are aligned and sign/zero-extended per funct3. A response timeout prevents permanent lockup.

## Interface
- TIMEOUT, 15: cycles allowed in REQ or RESP before abort; 0 disables the timeout.
- TO_W, 4: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- core_addr_i  in  32  byte address (core ALU result).
- core_wdata_i  in  32  store data, already lane-positioned.
- core_be_i  in  4  store byte enables from the LSU.
- core_funct3_i  in  3  load/store width code.
- core_rd_i  in  1  load request.
- core_wr_i  in  1  store request.
- core_rdata_o  out  32  extended load data.
- core_stall_o  out  1  hold PC and regfile.
- core_err_o  out  1  one-cycle error pulse.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_be_o  out  4  byte enables (0xF for reads).
- mem_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata_o  out  32  write data.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data word.

## Operation
FSM states: IDLE, REQ, RESP, DONE.
- IDLE: if core_wr_i or core_rd_i, latch addr, wdata, be, funct3 and op, then go to REQ. core_wr_i wins when both are high.
  - A write with core_be_i == 0 goes straight to DONE with no bus request.
- REQ: mem_req_o = 1; bus outputs come from latched values and are stable until grant.
  - On mem_gnt_i, a write goes to DONE and a read goes to RESP.
- RESP: wait for mem_rvalid_i. On the rvalid cycle, capture the extended data into core_rdata_o and go to DONE.
- DONE: stall is low for exactly one cycle and the core advances. Requests present in DONE are ignored (they are the completed access), then the FSM returns to IDLE.
- core_stall_o is combinational: (IDLE && (rd||wr)) || REQ || RESP.
- Load extension, with lane = addr[1:0]:
  - 000 LB: sign-extend byte at lane.
  - 001 LH: sign-extend half at addr[1].
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - Any other code is treated as LW.
- core_rdata_o holds its value until the next load completes.
- Timeout: the counter clears on entry to REQ and on grant, and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT, drop mem_req_o, go to DONE, pulse core_err_o in DONE, and set core_rdata_o to 0 for a read.
- mem_rvalid_i or mem_gnt_i received outside REQ/RESP is ignored. This covers stale responses after reset.

## Timing
- Reset values:
  - state = IDLE.
  - mem_req_o, mem_we_o, core_err_o = 0.
  - mem_be_o = 0; mem_addr_o, mem_wdata_o, core_rdata_o = 0.
  - Counter = 0.
  - core_stall_o follows its equation (high if a request is present).
- Load with zero-wait bus (gnt in the first REQ cycle, rvalid in the first RESP cycle): stall high 3 cycles. Data is valid in the DONE cycle, 3 cycles after the request appears.
- Store with immediate gnt: stall high 2 cycles.
- Each extra gnt or rvalid wait cycle adds one stall cycle.
- Back-to-back accesses: a new request is accepted in the IDLE cycle immediately after DONE. Minimum spacing is 4 cycles per load and 3 per store.
- Asynchronous reset mid-transaction: mem_req_o drops immediately and the transaction is abandoned with no error pulse.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - In IDLE, detect a misaligned access: funct3[1:0] == 01 with addr[0] = 1, or funct3[1:0] == 10 with addr[1:0] != 0.
  - On detection, issue no bus request, go directly to DONE (stall high 1 cycle), pulse core_err_o, and set rdata to 0 for a load.
- DMEM_MISALIGN_CHECK_EN undefined: no check. The address is word-aligned silently, and lanes and byte enables are used as given.

## Test plan
- LB at 0x103, mem word 0x80AA_BBCC, gnt/rvalid immediate -> mem_addr_o = 0x100, stall high 3 cycles, core_rdata_o = 0xFFFF_FF80; the same access as LBU -> 0x0000_0080.
- SW at 0x200 with data 0xDEAD_BEEF, be = 0xF, gnt delayed 2 cycles -> one write transaction with mem_we_o = 1 and be = 0xF, stall high 4 cycles, exactly one grant consumed.
- LHU at 0x402, rvalid never asserted, TIMEOUT = 15 -> mem_req_o drops, core_err_o pulses once, core_rdata_o = 0, FSM back in IDLE.
- Reset asserted during RESP, then a stale rvalid arrives after reset -> outputs at reset values, rvalid ignored, next load completes normally.
- With DMEM_MISALIGN_CHECK_EN, LW at 0x1 -> no mem_req_o, stall high 1 cycle, core_err_o pulses; without the macro -> read issued at 0x0.
- Store with be = 0 -> no bus request, stall high 1 cycle, no error.

Source files
------------

// File: rtl/dmem_bridge.sv
// Data-side bridge from the core's combinational data port to a pipelined req/gnt/rvalid bus.
// Optional misaligned-access trap: define DMEM_MISALIGN_CHECK_EN.
module dmem_bridge #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_be_i,
    input  logic [2:0]  core_funct3_i,
    input  logic        core_rd_i,
    input  logic        core_wr_i,
    output logic [31:0] core_rdata_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic [1:0]      lane_q;
    logic [2:0]      funct3_q;
    logic            start;
    logic            misaligned;
    logic            skip_bus;
    logic            to_hit;

    assign start    = core_rd_i | core_wr_i;
    assign skip_bus = misaligned | (core_wr_i & (core_be_i == 4'b0000));
    assign to_hit   = (TIMEOUT != 0) && (to_cnt_q == TO_LIMIT);

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (core_funct3_i[1:0])
            2'b01:   misaligned = core_addr_i[0];
            2'b10:   misaligned = |core_addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    function automatic logic [31:0] extend(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: a default assignment first keeps this combinational block from inferring latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = skip_bus ? S_DONE : S_REQ;
            S_REQ: begin
                if (to_hit)         state_d = S_DONE;
                else if (mem_gnt_i) state_d = mem_we_o ? S_DONE : S_RESP;
            end
            S_RESP: if (to_hit || mem_rvalid_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request is dropped in the cycle the timeout fires so a late grant cannot be taken.
    always_comb begin
        core_stall_o = 1'b0;
        mem_req_o    = 1'b0;
        case (state_q)
            S_IDLE: core_stall_o = start;
            S_REQ: begin
                core_stall_o = 1'b1;
                mem_req_o    = !to_hit;
            end
            S_RESP:  core_stall_o = 1'b1;
            default: core_stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (to_hit || mem_gnt_i) to_cnt_q <= '0;
                    else if (TIMEOUT != 0)   to_cnt_q <= to_cnt_q + TO_W'(1);
                end
                S_RESP: begin
                    if (to_hit)            to_cnt_q <= '0;
                    else if (TIMEOUT != 0) to_cnt_q <= to_cnt_q + TO_W'(1);
                end
                default: to_cnt_q <= '0;
            endcase
        end
    end

    // core_err_o is set only on the edge into DONE, which lasts one cycle, so it is a clean pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_we_o     <= 1'b0;
            mem_be_o     <= 4'h0;
            mem_addr_o   <= 32'h0;
            mem_wdata_o  <= 32'h0;
            lane_q       <= 2'b00;
            funct3_q     <= 3'b000;
            core_rdata_o <= 32'h0;
            core_err_o   <= 1'b0;
        end else begin
            core_err_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mem_we_o    <= core_wr_i;
                        mem_be_o    <= core_wr_i ? core_be_i : 4'hF;
                        mem_addr_o  <= {core_addr_i[31:2], 2'b00};
                        mem_wdata_o <= core_wdata_i;
                        lane_q      <= core_addr_i[1:0];
                        funct3_q    <= core_funct3_i;
                        if (misaligned) begin
                            core_err_o <= 1'b1;
                            if (!core_wr_i) core_rdata_o <= 32'h0;
                        end
                    end
                end
                S_REQ: begin
                    if (to_hit) begin
                        core_err_o <= 1'b1;
                        if (!mem_we_o) core_rdata_o <= 32'h0;
                    end
                end
                S_RESP: begin
                    if (to_hit) begin
                        core_err_o   <= 1'b1;
                        core_rdata_o <= 32'h0;
                    end else if (mem_rvalid_i) begin
                        core_rdata_o <= extend(mem_rdata_i, lane_q, funct3_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: loads, stores, timeouts, reset mid-transaction.
// Honours DMEM_MISALIGN_CHECK_EN to pick the expected misaligned-access behaviour.
module tb_dmem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [3:0]  core_be_i;
    logic [2:0]  core_funct3_i;
    logic        core_rd_i, core_wr_i;
    logic [31:0] core_rdata_o;
    logic        core_stall_o, core_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_errors = 0;

    int          res_stall, res_req, res_grants, res_err;
    logic        res_done;
    logic [31:0] res_rdata, bus_addr, bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_be;

    always #5 clk_i = ~clk_i;

    dmem_bridge dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_be_i    (core_be_i),
        .core_funct3_i(core_funct3_i),
        .core_rd_i    (core_rd_i),
        .core_wr_i    (core_wr_i),
        .core_rdata_o (core_rdata_o),
        .core_stall_o (core_stall_o),
        .core_err_o   (core_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; holds the request until stall drops (the DONE cycle),
    // playing the bus side with the given grant / rvalid delays (rv_dly < 0: never).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic [2:0] f3,
                             input int gnt_dly, input int rv_dly, input logic [31:0] word);
        int   req_wait = 0;
        int   rv_wait  = 0;
        logic pend     = 1'b0;
        res_stall = 0; res_req = 0; res_grants = 0; res_err = 0; res_done = 1'b0;
        res_rdata = 32'hx; bus_addr = 32'hx; bus_wdata = 32'hx; bus_we = 1'bx; bus_be = 4'hx;
        core_addr_i = addr; core_wdata_i = wdata; core_be_i = be; core_funct3_i = f3;
        core_wr_i = we; core_rd_i = !we;
        for (int cyc = 0; cyc < 100 && !res_done; cyc++) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
            if (mem_req_o) begin
                if (req_wait >= gnt_dly) mem_gnt_i = 1'b1;
                req_wait++;
            end
            if (pend && rv_dly >= 0) begin
                if (rv_wait >= rv_dly) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = word; pend = 1'b0;
                end
                rv_wait++;
            end
            #1;
            if (core_stall_o) res_stall++;
            if (core_err_o)   res_err++;
            if (mem_req_o)    res_req++;
            if (mem_req_o && mem_gnt_i) begin
                res_grants++;
                bus_addr = mem_addr_o; bus_wdata = mem_wdata_o; bus_we = mem_we_o; bus_be = mem_be_o;
                if (!mem_we_o) pend = 1'b1;
            end
            if (!core_stall_o) begin
                res_done  = 1'b1;
                res_rdata = core_rdata_o;
                core_rd_i = 1'b0; core_wr_i = 1'b0;
            end
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        core_rd_i = 1'b0; core_wr_i = 1'b0;
        check("completed", {31'h0, res_done}, 32'h1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads[6] = '{
        '{32'h0000_0103, 3'b000, 32'hFFFF_FF80},
        '{32'h0000_0103, 3'b100, 32'h0000_0080},
        '{32'h0000_0101, 3'b000, 32'hFFFF_FFBB},
        '{32'h0000_0402, 3'b001, 32'hFFFF_80AA},
        '{32'h0000_0400, 3'b101, 32'h0000_BBCC},
        '{32'h0000_0100, 3'b011, 32'h80AA_BBCC}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b0;
        core_addr_i = 32'h0; core_wdata_i = 32'h0; core_be_i = 4'h0; core_funct3_i = 3'b0;
        core_rd_i = 1'b0; core_wr_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req",   {31'h0, mem_req_o},    32'h0);
        check("rst_we",    {31'h0, mem_we_o},     32'h0);
        check("rst_be",    {28'h0, mem_be_o},     32'h0);
        check("rst_addr",  mem_addr_o,            32'h0);
        check("rst_wdata", mem_wdata_o,           32'h0);
        check("rst_rdata", core_rdata_o,          32'h0);
        check("rst_err",   {31'h0, core_err_o},   32'h0);
        check("rst_stall_idle", {31'h0, core_stall_o}, 32'h0);
        core_rd_i = 1'b1;
        #1;
        check("rst_stall_req", {31'h0, core_stall_o}, 32'h1);
        core_rd_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Zero-wait loads across every extension mode and lane.
        foreach (loads[i]) begin
            do_access(1'b0, loads[i].addr, 32'h0, 4'h0, loads[i].f3, 0, 0, 32'h80AA_BBCC);
            check($sformatf("load%0d_rdata", i), res_rdata, loads[i].exp);
            check($sformatf("load%0d_stall", i), res_stall, 3);
            check($sformatf("load%0d_addr", i), bus_addr, {loads[i].addr[31:2], 2'b00});
            check($sformatf("load%0d_be", i), {28'h0, bus_be}, 32'hF);
            check($sformatf("load%0d_we", i), {31'h0, bus_we}, 32'h0);
            check($sformatf("load%0d_err", i), res_err, 0);
        end

        // Store with grant delayed two cycles; last load value must survive it.
        do_access(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF, 3'b010, 2, 0, 32'h0);
        check("sw_stall",  res_stall, 4);
        check("sw_grants", res_grants, 1);
        check("sw_req",    res_req, 3);
        check("sw_addr",   bus_addr, 32'h0000_0200);
        check("sw_we",     {31'h0, bus_we}, 32'h1);
        check("sw_be",     {28'h0, bus_be}, 32'hF);
        check("sw_wdata",  bus_wdata, 32'hDEAD_BEEF);
        check("sw_err",    res_err, 0);
        check("sw_rdata_hold", res_rdata, 32'h80AA_BBCC);

        // Store with no byte enables never touches the bus.
        do_access(1'b1, 32'h0000_0204, 32'h1111_2222, 4'h0, 3'b000, 0, 0, 32'h0);
        check("be0_stall", res_stall, 1);
        check("be0_req",   res_req, 0);
        check("be0_err",   res_err, 0);

        // Read response never arrives: 1 IDLE + 1 REQ + 16 RESP stall cycles.
        do_access(1'b0, 32'h0000_0402, 32'h0, 4'h0, 3'b101, 0, -1, 32'h0);
        check("to_rd_stall",  res_stall, 18);
        check("to_rd_grants", res_grants, 1);
        check("to_rd_err",    res_err, 1);
        check("to_rd_rdata",  res_rdata, 32'h0);
        #1;
        check("to_rd_idle_stall", {31'h0, core_stall_o}, 32'h0);
        check("to_rd_idle_err",   {31'h0, core_err_o},   32'h0);
        @(negedge clk_i);

        // Grant never arrives: request is high for 15 cycles, dropped on the 16th.
        do_access(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'h3, 3'b001, 1000, 0, 32'h0);
        check("to_wr_stall",  res_stall, 17);
        check("to_wr_req",    res_req, 15);
        check("to_wr_grants", res_grants, 0);
        check("to_wr_err",    res_err, 1);

        // Misaligned word load.
        do_access(1'b0, 32'h0000_0001, 32'h0, 4'h0, 3'b010, 0, 0, 32'h1234_5678);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_stall", res_stall, 1);
        check("mis_req",   res_req, 0);
        check("mis_err",   res_err, 1);
        check("mis_rdata", res_rdata, 32'h0);
`else
        check("mis_stall", res_stall, 3);
        check("mis_addr",  bus_addr, 32'h0);
        check("mis_err",   res_err, 0);
        check("mis_rdata", res_rdata, 32'h1234_5678);
`endif

        // Reset while in REQ: request must fall without waiting for a clock.
        core_addr_i = 32'h0000_0300; core_funct3_i = 3'b010; core_rd_i = 1'b1;
        @(negedge clk_i);
        core_rd_i = 1'b0;
        #1;
        check("pre_rst_req", {31'h0, mem_req_o}, 32'h1);
        #1 rst_n_i = 1'b0;
        #1;
        check("rst_req_drop", {31'h0, mem_req_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Reset while in RESP, then a stale rvalid afterwards.
        do_access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 3'b010, 0, 0, 32'h0BAD_F00D);
        core_addr_i = 32'h0000_0308; core_funct3_i = 3'b010; core_rd_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; core_rd_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        check("resp_rst_stall", {31'h0, core_stall_o}, 32'h0);
        check("resp_rst_rdata", core_rdata_o, 32'h0);
        check("resp_rst_err",   {31'h0, core_err_o}, 32'h0);
        check("resp_rst_be",    {28'h0, mem_be_o}, 32'h0);
        check("resp_rst_addr",  mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("stale_stall", {31'h0, core_stall_o}, 32'h0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        #1;
        check("stale_rdata", core_rdata_o, 32'h0);
        check("stale_err",   {31'h0, core_err_o}, 32'h0);
        @(negedge clk_i);

        do_access(1'b0, 32'h0000_0300, 32'h0, 4'h0, 3'b010, 0, 0, 32'h1357_9BDF);
        check("post_rst_rdata", res_rdata, 32'h1357_9BDF);
        check("post_rst_stall", res_stall, 3);
        check("post_rst_addr",  bus_addr, 32'h0000_0300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
